// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential arithmetic units: FSM state
// encodings and the counter-width helper.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of bits needed to count value distinct states (ceil(log2(value))).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned w;
        v = (value > 0) ? value - 1 : 0;
        w = 0;
        while (v > 0) begin
            w++;
            v = v >> 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the
// shifted partial remainder, producing the next remainder and quotient bit.
module seq_div_step #(
    parameter int unsigned N = 8
) (
    input  logic [N:0]   shift_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] rem_o,
    output logic         q_bit_o
);

    logic [N:0] trial;

    // Trial subtract; the MSB of the N+1-bit result is the borrow.
    // Either kept value is below 2^N, so the remainder is returned N bits wide.
    always_comb begin
        trial   = shift_i - {1'b0, divisor_i};
        q_bit_o = ~trial[N];
        rem_o   = q_bit_o ? trial[N-1:0] : shift_i[N-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: unsigned N-bit dividend / N-bit divisor,
// one quotient bit per clock, with start/valid handshake and divide-by-zero flag.
module seq_divider #(
    parameter int unsigned N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         valid,
    output logic         busy,
    output logic         div_by_zero
);

    import seq_divider_pkg::*;

    localparam int unsigned CW = (clog2(N) > 0) ? clog2(N) : 1;

    state_e         state_q, state_d;
    logic [N-1:0]   q_work_q, q_work_d;
    logic [N-1:0]   r_work_q, r_work_d;
    logic [N-1:0]   d_work_q, d_work_d;
    logic [CW-1:0]  count_q, count_d;
    logic [N-1:0]   quotient_q, quotient_d;
    logic [N-1:0]   remainder_q, remainder_d;
    logic           dbz_q, dbz_d;

    logic           accept;
    logic           divisor_zero;
    logic [N:0]     shift;
    logic [N-1:0]   step_rem;
    logic           step_qbit;
    logic [N-1:0]   q_next;

    assign accept       = start && (state_q != CALC);
    assign divisor_zero = (divisor == '0);
    assign shift        = {r_work_q, q_work_q[N-1]};
    assign q_next       = {q_work_q[N-2:0], step_qbit};

    seq_div_step #(.N(N)) u_step (
        .shift_i   (shift),
        .divisor_i (d_work_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept from IDLE/DONE, iterate N edges in CALC.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        valid = (state_q == DONE);
        busy  = (state_q == CALC);
    end

    // Datapath next-state: load on accept, one restoring step per CALC edge.
    always_comb begin
        q_work_d    = q_work_q;
        r_work_d    = r_work_q;
        d_work_d    = d_work_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        if (accept) begin
            q_work_d = dividend;
            r_work_d = '0;
            d_work_d = divisor;
            count_d  = CW'(N - 1);
            dbz_d    = divisor_zero;
            if (divisor_zero) begin
                quotient_d  = '1;
                remainder_d = dividend;
            end
        end else if (state_q == CALC) begin
            q_work_d = q_next;
            r_work_d = step_rem;
            count_d  = count_q - CW'(1);
            if (count_q == '0) begin
                quotient_d  = q_next;
                remainder_d = step_rem;
            end
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_work_q    <= '0;
            r_work_q    <= '0;
            d_work_q    <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            q_work_q    <= q_work_d;
            r_work_q    <= r_work_d;
            d_work_q    <= d_work_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=8): vector table, hand-written
// multi-cycle sequences and a randomized run against an arithmetic model.
module tb_seq_divider;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       valid;
    logic       busy;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;
    int overlap  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } vec_t;

    seq_divider #(.N(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .valid       (valid),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for valid; latency counts the accepting edge as 1.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int busy_cycles);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        lat = 0;
        busy_cycles = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
            if (lat == 1) start = 1'b0;
            if (busy) busy_cycles++;
            if (valid && busy) overlap++;
        end while (!valid && lat < 40);
    endtask

    vec_t vecs[12];

    initial begin
        int lat;
        int bc;
        int edges;
        int vcount;
        logic [7:0] a;
        logic [7:0] b;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        vecs[0]  = '{8'd222, 8'd183, 8'd1,   8'd39,  1'b0};
        vecs[1]  = '{8'd183, 8'd7,   8'd26,  8'd1,   1'b0};
        vecs[2]  = '{8'd30,  8'd0,   8'd255, 8'd30,  1'b1};
        vecs[3]  = '{8'd30,  8'd219, 8'd0,   8'd30,  1'b0};
        vecs[4]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vecs[5]  = '{8'd252, 8'd239, 8'd1,   8'd13,  1'b0};
        vecs[6]  = '{8'd100, 8'd10,  8'd10,  8'd0,   1'b0};
        vecs[7]  = '{8'd7,   8'd255, 8'd0,   8'd7,   1'b0};
        vecs[8]  = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};
        vecs[9]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        vecs[10] = '{8'd200, 8'd3,   8'd66,  8'd2,   1'b0};
        vecs[11] = '{8'd1,   8'd1,   8'd1,   8'd0,   1'b0};

        // Reset state, while asserted and after release.
        #15;
        check("rst_quotient",  32'(quotient),  0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_valid",     32'(valid),     0);
        check("rst_busy",      32'(busy),      0);
        check("rst_dbz",       32'(div_by_zero), 0);
        #10;
        reset = 1'b0;
        @(negedge clock);
        check("idle_valid", 32'(valid), 0);
        check("idle_busy",  32'(busy),  0);

        // Vector table.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, bc);
            check($sformatf("vec%0d_q", i),   32'(quotient),    32'(vecs[i].q));
            check($sformatf("vec%0d_r", i),   32'(remainder),   32'(vecs[i].r));
            check($sformatf("vec%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
            check($sformatf("vec%0d_lat", i), 32'(lat),         vecs[i].dbz ? 1 : 9);
            check($sformatf("vec%0d_busy", i), 32'(bc),         vecs[i].dbz ? 0 : 8);
        end

        // Operand changes and start during CALC are ignored.
        @(negedge clock);
        dividend = 8'd183;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = 8'd1;
        divisor  = 8'd1;
        edges    = 1;
        while (!valid && edges < 40) begin
            @(posedge clock);
            #1;
            edges++;
            if (edges == 3) start = 1'b1;
            if (edges == 5) start = 1'b0;
        end
        check("calc_ignore_lat", 32'(edges),     9);
        check("calc_ignore_q",   32'(quotient),  26);
        check("calc_ignore_r",   32'(remainder), 1);

        // Back-to-back with start held high: one-cycle valid pulse per operation.
        @(negedge clock);
        dividend = 8'd255;
        divisor  = 8'd1;
        start    = 1'b1;
        vcount   = 0;
        for (int e = 1; e <= 27; e++) begin
            @(posedge clock);
            #1;
            if (e == 1) begin
                dividend = 8'd252;
                divisor  = 8'd239;
            end
            if (valid) vcount++;
            if (valid && busy) overlap++;
            if (e == 9) begin
                check("b2b_first_valid", 32'(valid),     1);
                check("b2b_first_q",     32'(quotient),  255);
                check("b2b_first_r",     32'(remainder), 0);
            end
            if (e == 10) check("b2b_pulse1_end", 32'(valid), 0);
            if (e == 18) begin
                check("b2b_second_valid", 32'(valid),     1);
                check("b2b_second_q",     32'(quotient),  1);
                check("b2b_second_r",     32'(remainder), 13);
            end
            if (e == 19) begin
                check("b2b_pulse2_end", 32'(valid), 0);
                start = 1'b0;
            end
        end
        check("b2b_valid_count", 32'(vcount), 3);

        // Reset during the 4th CALC cycle aborts immediately.
        @(negedge clock);
        dividend = 8'd183;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #5;
        check("midcalc_busy", 32'(busy),     1);
        check("midcalc_hold", 32'(quotient), 1);
        reset = 1'b1;
        #1;
        check("abort_quotient",  32'(quotient),  0);
        check("abort_remainder", 32'(remainder), 0);
        check("abort_valid",     32'(valid),     0);
        check("abort_busy",      32'(busy),      0);
        check("abort_dbz",       32'(div_by_zero), 0);
        @(negedge clock);
        reset = 1'b0;
        run_op(8'd0, 8'd5, lat, bc);
        check("post_reset_q",   32'(quotient),  0);
        check("post_reset_r",   32'(remainder), 0);
        check("post_reset_lat", 32'(lat),       9);

        // Random operands against the arithmetic model.
        for (int k = 0; k < 1000; k++) begin
            a = 8'($urandom_range(255, 0));
            b = 8'($urandom_range(255, 1));
            run_op(a, b, lat, bc);
            check($sformatf("rnd%0d_q %0d/%0d", k, a, b), 32'(quotient),  32'(a / b));
            check($sformatf("rnd%0d_r %0d/%0d", k, a, b), 32'(remainder), 32'(a % b));
            check($sformatf("rnd%0d_identity", k),
                  32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            check($sformatf("rnd%0d_r_lt_d", k), 32'(remainder < b), 1);
            check($sformatf("rnd%0d_lat", k), 32'(lat), 9);
        end

        check("valid_busy_overlap", 32'(overlap), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
